// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: pipeline-side initiator for the multiply/divide unit.
// Accepts decoded MD requests, issues one-cycle op pulses, and tracks MD latency with a
// shadow counter. It also returns mfhi/mflo results, counts stall cycles and flags
// protocol errors.
module md_issue_ctrl #(
   parameter int unsigned LAT_MULT    = 5,
   parameter int unsigned LAT_DIV     = 10,
   parameter int unsigned LAT_BDS     = 10,
   parameter int unsigned CNT_W       = 4,
   parameter int unsigned STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   req_valid,
   input  logic [3:0]             req_op,
   input  logic [31:0]            req_rs,
   input  logic [31:0]            req_rt,
   output logic                   req_ready,
   output logic                   stall,
   output logic [3:0]             md_op,
   output logic [31:0]            md_rs,
   output logic [31:0]            md_rt,
   input  logic                   md_busy,
   input  logic [31:0]            md_out,
   output logic                   res_valid,
   output logic [31:0]            res_data,
   output logic [STALL_CNT_W-1:0] stall_cnt,
   output logic                   sync_err,
   output logic                   op_err
);

   localparam logic [3:0] OpNone  = 4'd0;
   localparam logic [3:0] OpMult  = 4'd1;
   localparam logic [3:0] OpMultu = 4'd2;
   localparam logic [3:0] OpDiv   = 4'd3;
   localparam logic [3:0] OpDivu  = 4'd4;
   localparam logic [3:0] OpMfhi  = 4'd5;
   localparam logic [3:0] OpMflo  = 4'd6;
   localparam logic [3:0] OpBds   = 4'd9;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait
   } state_e;

   // Ops that keep MD busy for a latency window
   function automatic logic is_start(input logic [3:0] op);
      return (op == OpMult) || (op == OpMultu) || (op == OpDiv) ||
             (op == OpDivu) || (op == OpBds);
   endfunction

   function automatic logic [CNT_W-1:0] lat_of(input logic [3:0] op);
      logic [CNT_W-1:0] lat;
      lat = '0;
      if ((op == OpMult) || (op == OpMultu)) begin
         lat = CNT_W'(LAT_MULT);
      end else if ((op == OpDiv) || (op == OpDivu)) begin
         lat = CNT_W'(LAT_DIV);
      end else if (op == OpBds) begin
         lat = CNT_W'(LAT_BDS);
      end
      return lat;
   endfunction

   state_e                 state_q, state_d;
   logic [3:0]             md_op_q, md_op_d;
   logic [31:0]            md_rs_q, md_rs_d;
   logic [31:0]            md_rt_q, md_rt_d;
   logic [CNT_W-1:0]       shadow_q, shadow_d;
   logic                   res_valid_q, res_valid_d;
   logic [31:0]            res_data_q, res_data_d;
   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic                   sync_err_q, sync_err_d;
   logic                   op_err_q, op_err_d;

   logic md_start;
   logic shadow_idle;
   logic accept;
   logic op_bad;
   logic issue_real;

   // Handshake: blocked while MD is busy, while the shadow counts, and in the gap cycle
   // right after a start-type issue before MD has raised busy.
   assign md_start    = is_start(md_op_q);
   assign shadow_idle = (shadow_q == '0);
   assign req_ready   = ~md_busy & shadow_idle & ~md_start;
   assign accept      = req_valid & req_ready;
   assign stall       = req_valid & ~req_ready;
   assign op_bad      = (req_op > OpBds);
   assign issue_real  = accept & ~op_bad & (req_op != OpNone);

   // Issue register next-state: one-cycle op pulse, operands hold between issues
   always_comb begin
      md_op_d  = OpNone;
      md_rs_d  = md_rs_q;
      md_rt_d  = md_rt_q;
      op_err_d = op_err_q;
      if (accept) begin
         md_rs_d = req_rs;
         md_rt_d = req_rt;
         if (op_bad) begin
            op_err_d = 1'b1;
         end else begin
            md_op_d = req_op;
         end
      end
   end

   // Shadow latency counter: load on the edge after a start-type pulse, else count down
   always_comb begin
      shadow_d = shadow_q;
      if (md_start) begin
         shadow_d = lat_of(md_op_q);
      end else if (!shadow_idle) begin
         shadow_d = shadow_q - CNT_W'(1);
      end
   end

   // Result capture, stall counting and MD/shadow consistency check
   always_comb begin
      res_valid_d = (md_op_q == OpMfhi) || (md_op_q == OpMflo);
      res_data_d  = res_valid_d ? md_out : res_data_q;
      sync_err_d  = sync_err_q | (md_busy != ~shadow_idle);
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
      end
   end

   // Issue FSM next-state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (issue_real) begin
               state_d = StIssue;
            end
         end
         StIssue: begin
            if (md_start) begin
               state_d = StWait;
            end else if (issue_real) begin
               state_d = StIssue;
            end else begin
               state_d = StIdle;
            end
         end
         StWait: begin
            if (shadow_d == '0) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers; reset drops any op in flight
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         md_op_q     <= OpNone;
         md_rs_q     <= '0;
         md_rt_q     <= '0;
         shadow_q    <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         stall_cnt_q <= '0;
         sync_err_q  <= 1'b0;
         op_err_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         md_op_q     <= md_op_d;
         md_rs_q     <= md_rs_d;
         md_rt_q     <= md_rt_d;
         shadow_q    <= shadow_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         stall_cnt_q <= stall_cnt_d;
         sync_err_q  <= sync_err_d;
         op_err_q    <= op_err_d;
      end
   end

   assign md_op     = md_op_q;
   assign md_rs     = md_rs_q;
   assign md_rt     = md_rt_q;
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign stall_cnt = stall_cnt_q;
   assign sync_err  = sync_err_q;
   assign op_err    = op_err_q;

endmodule
